// File: rtl/main_mem_pkg.sv
// Shared constants, burst-size encodings and burst-length helper for the main memory model.
package main_mem_pkg;

  localparam logic [31:0] START_ADDRESS = 32'h8002_0000;

  typedef enum logic [1:0] {
    AccWord    = 2'b00,
    AccBurst4  = 2'b01,
    AccBurst8  = 2'b10,
    AccBurst16 = 2'b11
  } acc_size_e;

  function automatic int unsigned burst_len(acc_size_e sz);
    int unsigned len;
    len = 1;
    unique case (sz)
      AccWord:    len = 1;
      AccBurst4:  len = 4;
      AccBurst8:  len = 8;
      AccBurst16: len = 16;
      default:    len = 1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/main_mem_if.sv
// Request/response bus of the main memory; all vectors use bit 0 = MSB ordering.
interface main_mem_if;

  logic [0:31] addr;
  logic [0:31] data_in;
  logic [0:31] data_out;
  logic [0:1]  acc_size;
  logic        wren;
  logic        busy;
  logic        enable;

  modport master (
    output addr, data_in, acc_size, wren, enable,
    input  data_out, busy
  );

  modport slave (
    input  addr, data_in, acc_size, wren, enable,
    output data_out, busy
  );

endinterface

// File: rtl/main_mem_array.sv
// Word-wide storage built from four byte lanes; lane 0 holds the lowest byte address (bits [0:7]).
module main_mem_array #(
  parameter int unsigned Words  = 262144,
  parameter int unsigned WordAw = $clog2(Words)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [WordAw-1:0] idx_i,
  input  logic [0:31]       wdata_i,
  output logic [0:31]       rdata_o
);

  logic [7:0] lane0_q [Words];
  logic [7:0] lane1_q [Words];
  logic [7:0] lane2_q [Words];
  logic [7:0] lane3_q [Words];

  // No reset: contents survive reset by design.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      lane0_q[idx_i] <= wdata_i[0:7];
      lane1_q[idx_i] <= wdata_i[8:15];
      lane2_q[idx_i] <= wdata_i[16:23];
      lane3_q[idx_i] <= wdata_i[24:31];
    end
  end

  assign rdata_o = {lane0_q[idx_i], lane1_q[idx_i], lane2_q[idx_i], lane3_q[idx_i]};

endmodule

// File: rtl/main_mem.sv
// Burst-capable main memory: burst sequencing, beat address generation and window check
// in front of a word-wide byte-lane array.
module main_mem #(
  parameter logic [31:0] START_ADDRESS = main_mem_pkg::START_ADDRESS,
  parameter int unsigned DEPTH_BYTES   = 1048576
) (
  input logic       clock,
  input logic       reset,
  main_mem_if.slave bus
);
  import main_mem_pkg::*;

  localparam int unsigned Words  = DEPTH_BYTES / 4;
  localparam int unsigned WordAw = $clog2(Words);

  logic [31:0] base_q, base_d;
  logic [3:0]  beat_q, beat_d;
  logic [3:0]  last_q, last_d;
  logic        wren_q, wren_d;
  logic        busy_q, busy_d;
  logic [0:31] data_out_q, data_out_d;

  logic [31:0]       req_addr;
  logic [31:0]       beat_addr;
  logic [31:0]       word_off;
  logic              beat_valid;
  logic              beat_wr;
  logic              in_range;
  logic              mem_we;
  logic [0:31]       rdata;
  logic [WordAw-1:0] word_idx;
  acc_size_e         req_size;

  assign req_addr = 32'(bus.addr) & 32'hFFFF_FFFC;
  assign req_size = acc_size_e'(bus.acc_size);

  always_comb begin
    base_d     = base_q;
    beat_d     = beat_q;
    last_d     = last_q;
    wren_d     = wren_q;
    busy_d     = busy_q;
    beat_valid = 1'b0;
    beat_wr    = 1'b0;
    beat_addr  = '0;
    if (busy_q) begin
      // Bus inputs other than data_in are ignored until the burst completes.
      beat_valid = 1'b1;
      beat_wr    = wren_q;
      beat_addr  = base_q + {26'b0, beat_q, 2'b00};
      beat_d     = 4'(beat_q + 4'd1);
      if (beat_q == last_q) busy_d = 1'b0;
    end else if (bus.enable) begin
      beat_valid = 1'b1;
      beat_wr    = bus.wren;
      beat_addr  = req_addr;
      base_d     = req_addr;
      wren_d     = bus.wren;
      beat_d     = 4'd1;
      last_d     = 4'(burst_len(req_size) - 1);
      busy_d     = (req_size != AccWord);
    end
  end

  // Unsigned offset from the window base; addresses below the base wrap to huge offsets.
  assign word_off = (beat_addr - START_ADDRESS) >> 2;
  assign in_range = word_off < 32'(Words);
  assign word_idx = word_off[WordAw-1:0];
  assign mem_we   = beat_valid & beat_wr & in_range;

  always_comb begin
    data_out_d = data_out_q;
    if (beat_valid && !beat_wr) data_out_d = in_range ? rdata : '0;
  end

  main_mem_array #(
    .Words  (Words),
    .WordAw (WordAw)
  ) u_array (
    .clk_i   (clock),
    .we_i    (mem_we),
    .idx_i   (word_idx),
    .wdata_i (bus.data_in),
    .rdata_o (rdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      base_q     <= '0;
      beat_q     <= '0;
      last_q     <= '0;
      wren_q     <= 1'b0;
      busy_q     <= 1'b0;
      data_out_q <= '0;
    end else begin
      base_q     <= base_d;
      beat_q     <= beat_d;
      last_q     <= last_d;
      wren_q     <= wren_d;
      busy_q     <= busy_d;
      data_out_q <= data_out_d;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_main_mem.sv
// Self-checking bench for main_mem: directed vector table, burst/reset sequences and
// randomized bursts against a byte-level associative-array model.
module tb_main_mem;

  localparam logic [31:0] Start = 32'h8002_0000;
  localparam int unsigned Depth = 1048576;

  logic clock;
  logic reset;
  main_mem_if bus ();

  main_mem #(
    .START_ADDRESS (Start),
    .DEPTH_BYTES   (Depth)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks;
  int n_fail;

  logic [7:0]  mem_m [bit [31:0]];
  logic [31:0] exp_out;
  bit          exp_known;
  logic [31:0] wd [16];
  logic [31:0] rd [16];
  int          busy_cnt;

  typedef struct {
    bit          en;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_window(input logic [31:0] a);
    longint unsigned la;
    la = longint'(a);
    return (la >= longint'(Start)) && (la < longint'(Start) + longint'(Depth));
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] w);
    if (in_window(a)) begin
      mem_m[a]     = w[31:24];
      mem_m[a + 1] = w[23:16];
      mem_m[a + 2] = w[15:8];
      mem_m[a + 3] = w[7:0];
    end
  endfunction

  function automatic bit model_read(input logic [31:0] a, output logic [31:0] w);
    w = 32'h0;
    if (!in_window(a)) return 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (!mem_m.exists(a + 32'(i))) return 1'b0;
      w = {w[23:0], mem_m[a + 32'(i)]};
    end
    return 1'b1;
  endfunction

  // Runs one access; wd[] supplies write data, rd[] collects read results, busy_cnt counts
  // cycles with busy high. Other bus inputs are scrambled while the burst is in flight.
  task automatic do_burst(input bit wr, input logic [31:0] a, input logic [1:0] sz);
    int          n;
    logic [31:0] base;
    logic [31:0] ba;
    logic [31:0] w;
    n        = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 4 : (sz == 2'd2) ? 8 : 16;
    base     = a & ~32'h3;
    busy_cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      if (k == 0) begin
        bus.enable   = 1'b1;
        bus.wren     = wr;
        bus.addr     = a;
        bus.acc_size = sz;
      end else begin
        bus.enable   = 1'($urandom);
        bus.wren     = 1'($urandom);
        bus.addr     = $urandom;
        bus.acc_size = 2'($urandom);
      end
      bus.data_in = wd[k];
      ba = base + 32'(4 * k);
      @(posedge clock);
      #1;
      if (wr) model_write(ba, wd[k]);
      else begin
        exp_known = model_read(ba, w);
        exp_out   = w;
      end
      rd[k] = bus.data_out;
      if (bus.busy) busy_cnt++;
      check("busy", 32'(bus.busy), (k != n - 1) ? 32'd1 : 32'd0);
      if (exp_known) check("data_out", bus.data_out, exp_out);
    end
    @(negedge clock);
    bus.enable = 1'b0;
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    exp_out      = 32'h0;
    exp_known    = 1'b1;
    reset        = 1'b1;
    bus.enable   = 1'b0;
    bus.wren     = 1'b0;
    bus.addr     = '0;
    bus.data_in  = '0;
    bus.acc_size = '0;

    vecs[0]  = '{1, 1, 32'h8002_0000, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[1]  = '{1, 0, 32'h8002_0000, 32'h0,         32'hDEAD_BEEF};
    vecs[2]  = '{1, 1, 32'h8002_0004, 32'h1122_3344, 32'hDEAD_BEEF};
    vecs[3]  = '{1, 0, 32'h8002_0006, 32'h0,         32'h1122_3344};
    vecs[4]  = '{1, 1, 32'h8001_0000, 32'hCAFE_F00D, 32'h1122_3344};
    vecs[5]  = '{1, 0, 32'h8001_0000, 32'h0,         32'h0000_0000};
    vecs[6]  = '{1, 0, 32'h8002_0000, 32'h0,         32'hDEAD_BEEF};
    vecs[7]  = '{0, 1, 32'h8002_0000, 32'hFFFF_FFFF, 32'hDEAD_BEEF};
    vecs[8]  = '{1, 0, 32'h8002_0000, 32'h0,         32'hDEAD_BEEF};
    vecs[9]  = '{1, 1, 32'h8011_FFFC, 32'hA5A5_A5A5, 32'hDEAD_BEEF};
    vecs[10] = '{1, 0, 32'h8011_FFFF, 32'h0,         32'hA5A5_A5A5};
    vecs[11] = '{1, 1, 32'h8012_0000, 32'h1234_5678, 32'hA5A5_A5A5};
    vecs[12] = '{1, 0, 32'h8012_0000, 32'h0,         32'h0000_0000};

    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_data_out", bus.data_out, 32'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      @(negedge clock);
      bus.enable   = vecs[i].en;
      bus.wren     = vecs[i].wr;
      bus.addr     = vecs[i].addr;
      bus.data_in  = vecs[i].data;
      bus.acc_size = 2'b00;
      @(posedge clock);
      #1;
      if (vecs[i].en && vecs[i].wr) model_write(vecs[i].addr & ~32'h3, vecs[i].data);
      check($sformatf("vec%0d_data_out", i), bus.data_out, vecs[i].exp);
      check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'd0);
      exp_out = vecs[i].exp;
    end
    @(negedge clock);
    bus.enable = 1'b0;

    // Four-word write then read burst.
    for (int k = 0; k < 16; k++) wd[k] = 32'(k + 1);
    do_burst(1'b1, 32'h8002_0010, 2'b01);
    do_burst(1'b0, 32'h8002_0010, 2'b01);
    for (int k = 0; k < 4; k++) check($sformatf("burst4_rd%0d", k), rd[k], 32'(k + 1));
    check("burst4_busy_cycles", 32'(busy_cnt), 32'd3);

    // Burst wrapping past 2^32 never touches the window.
    for (int k = 0; k < 16; k++) wd[k] = 32'h5A5A_0000 + 32'(k);
    do_burst(1'b1, 32'hFFFF_FFF8, 2'b01);
    do_burst(1'b0, 32'hFFFF_FFF8, 2'b01);
    for (int k = 0; k < 4; k++) check($sformatf("wrap_rd%0d", k), rd[k], 32'h0);

    // Prefill the regions used by the random phase.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 16; k++) wd[k] = $urandom;
      do_burst(1'b1, Start + 32'(64 * r), 2'b11);
    end
    for (int k = 0; k < 16; k++) wd[k] = $urandom;
    do_burst(1'b1, Start + Depth - 64, 2'b11);

    // Reset in the middle of a 16-word read burst.
    @(negedge clock);
    bus.enable   = 1'b1;
    bus.wren     = 1'b0;
    bus.addr     = Start;
    bus.acc_size = 2'b11;
    repeat (4) @(posedge clock);
    @(negedge clock);
    bus.enable = 1'b0;
    check("midburst_busy_before_reset", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    check("reset_mid_busy", 32'(bus.busy), 32'd0);
    check("reset_mid_data_out", bus.data_out, 32'h0);
    @(posedge clock);
    #1;
    check("reset_hold_busy", 32'(bus.busy), 32'd0);
    @(negedge clock);
    reset   = 1'b0;
    exp_out = 32'h0;
    do_burst(1'b0, Start, 2'b00);
    check("after_reset_read", rd[0], {mem_m[Start], mem_m[Start + 1], mem_m[Start + 2],
                                      mem_m[Start + 3]});

    // Randomized bursts across the low window, the window top and just below the window.
    for (int t = 0; t < 150; t++) begin
      int          region;
      logic [31:0] a;
      region = $urandom_range(0, 2);
      a = (region == 0) ? Start + 32'($urandom_range(0, 191)) :
          (region == 1) ? Start + Depth - 64 + 32'($urandom_range(0, 60)) :
                          Start - 64 + 32'($urandom_range(0, 60));
      for (int k = 0; k < 16; k++) wd[k] = $urandom;
      do_burst(1'($urandom), a, 2'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/main_mem.md
MAIN_MEM -- requirements
Module: main_mem

Interface
REQ-001 Parameter START_ADDRESS, default 32'h80020000, byte address of the first memory byte.
REQ-002 Parameter DEPTH_BYTES, default 1048576, memory size in bytes (multiple of 64).
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 addr  input  [0:31]  byte address, bit 0 = MSB.
REQ-006 data_in  input  [0:31]  write data word, bit 0 = MSB.
REQ-007 data_out  output  [0:31]  registered read data word.
REQ-008 acc_size  input  [0:1]  burst length: 00 = 1 word, 01 = 4 words, 10 = 8 words, 11 = 16 words.
REQ-009 wren  input  1  1 = write access, 0 = read access.
REQ-010 busy  output  1  high while a multi-word burst is in progress.
REQ-011 enable  input  1  access request strobe; no access starts while low.

Function
REQ-012 Storage SHALL be byte-addressed and big-endian: the word at address A is bytes A..A+3, with byte A on data bits [0:7].
REQ-013 addr bits [30:31] SHALL be ignored; all accesses are word-aligned.
REQ-014 An access SHALL start on a rising edge with enable=1 and busy=0, capturing addr, acc_size and wren at that edge.
REQ-015 Beat k (0..N-1) of an N-word burst SHALL target address captured_addr + 4*k; beat 0 is performed on the start edge, and beat k on the k-th following edge.
REQ-016 Write beat: data_in sampled at that beat's edge SHALL be stored at the beat address.
REQ-017 Read beat: data_out SHALL present the word at the beat address after that beat's edge (one-cycle latency), one new word per cycle.
REQ-018 busy SHALL rise after the start edge when N>1 and fall after the edge performing beat N-1; it stays 0 for single-word accesses.
REQ-019 While busy=1, addr, acc_size, wren and enable SHALL be ignored; a burst cannot be aborted except by reset.
REQ-020 A beat address outside START_ADDRESS..START_ADDRESS+DEPTH_BYTES-1 SHALL suppress the write and make that beat's read return 32'h00000000.
REQ-021 Beat address arithmetic SHALL be 32-bit modulo 2^32; a wrap leaves the window and falls under REQ-020.
REQ-022 With no beat performed on an edge, data_out SHALL hold its previous value.
REQ-023 A read beat of an address written on the same edge SHALL return the pre-write contents.

Reset
REQ-024 reset=1 SHALL immediately force busy=0, data_out=32'h00000000 and the beat counter to idle, including mid-burst.
REQ-025 Memory contents SHALL NOT be cleared by reset.
REQ-026 The first access after reset release SHALL start on the first rising edge with reset=0 and enable=1.

Structure
REQ-027 A shared package SHALL hold START_ADDRESS, the acc_size encodings, and a burst-length function mapping acc_size to 1/4/8/16.
REQ-028 The byte storage array SHALL be a sub-module main_mem_array (one word read/write port, big-endian byte lanes); main_mem holds the burst counter, address generation and range check.

Verification
REQ-029 Single write 32'hDEADBEEF at 32'h80020000, then single read of the same address -> data_out=32'hDEADBEEF one cycle after the read edge; busy stays 0.
REQ-030 Write 32'h11223344 at 32'h80020004, then read address 32'h80020006 -> 32'h11223344 (low address bits ignored).
REQ-031 4-word write burst of 1,2,3,4 at 32'h80020010 (acc_size=01), then 4-word read burst -> data_out 1,2,3,4 on successive cycles; busy high for exactly 3 cycles.
REQ-032 Write 32'hCAFEF00D at 32'h80010000 (below window), then read it -> 32'h00000000; in-window contents unchanged.
REQ-033 Reset asserted during cycle 5 of a 16-word read burst -> busy and data_out 0 immediately; single read at 32'h80020000 after release returns stored data.
REQ-034 enable=0 with wren=1 and data 32'hFFFFFFFF at 32'h80020000 -> memory unchanged; data_out unchanged.
